// File: rtl/id_rf_pkg.sv
// Shared constants and helpers for the ID-stage register file and scoreboard.
package id_rf_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 6;
  localparam int unsigned DefCntW  = 2;

  // Partner register of a paired access: flip the low address bit.
  function automatic logic [31:0] partner(input logic [31:0] addr);
    return addr ^ 32'd1;
  endfunction

endpackage

// File: rtl/id_sb_cnt.sv
// One scoreboard counter: in-flight writes to a single register.
// Counts up on inc, down on dec, holds when both fire. Never wraps in either direction.
module id_sb_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count; a decrement at zero is a protocol error and is ignored.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && cnt_q != CntMax) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter state with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/id_regfile_sb.sv
// Decode-stage register file with per-register in-flight write scoreboard.
// NUM_RD combinational read ports, one (optionally paired) write-back port.
// Optional feature: define ID_RF_BYPASS_EN to forward write-back data to the read
// ports and to waive the RAW stall when the last pending write lands this cycle.
module id_regfile_sb
  import id_rf_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dec_valid,
  input  logic [NUM_RD*ADDR_W-1:0] dec_rs,
  input  logic [NUM_RD-1:0]        dec_rs_used,
  input  logic [ADDR_W-1:0]        dec_rd,
  input  logic                     dec_rd_we,
  input  logic                     dec_pair,
  input  logic                     iss,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     wb_pair,
  input  logic [DATA_W-1:0]        wb_data2,
  output logic                     hazard,
  output logic                     sb_busy
);

  localparam int unsigned      NumRegs = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CntMax  = '1;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [CNT_W-1:0]  cnt    [NumRegs];
  logic [ADDR_W-1:0] wb_partner, rd_partner;
  logic [ADDR_W-1:0] rs_addr [NUM_RD];
  logic [NUM_RD-1:0] raw;
  logic              sat;

  assign wb_partner = ADDR_W'(partner(32'(wb_addr)));
  assign rd_partner = ADDR_W'(partner(32'(dec_rd)));

  // Register array; register 0 is never written so it always reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NumRegs; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wb_en) begin
      if (wb_addr != '0) begin
        regs_q[wb_addr] <= wb_data;
      end
      if (wb_pair && wb_partner != '0) begin
        regs_q[wb_partner] <= wb_data2;
      end
    end
  end

  assign cnt[0] = '0;

  for (genvar r = 1; r < NumRegs; r++) begin : g_cnt
    localparam logic [ADDR_W-1:0] RegAddr = ADDR_W'(r);
    logic inc, dec;
    assign inc = iss & dec_rd_we & ((dec_rd == RegAddr) | (dec_pair & (rd_partner == RegAddr)));
    assign dec = wb_en & ((wb_addr == RegAddr) | (wb_pair & (wb_partner == RegAddr)));
    id_sb_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (inc),
      .dec (dec),
      .cnt (cnt[r])
    );
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [DATA_W-1:0] data;
    logic              pending;
    assign rs_addr[i] = dec_rs[i*ADDR_W +: ADDR_W];
    assign pending    = dec_rs_used[i] & (rs_addr[i] != '0) & (cnt[rs_addr[i]] != '0);
`ifdef ID_RF_BYPASS_EN
    logic hit_lo, hit_hi;
    assign hit_lo = wb_en & (rs_addr[i] == wb_addr);
    assign hit_hi = wb_en & wb_pair & (rs_addr[i] == wb_partner);
    // Read mux with forwarding of the write-back landing this cycle.
    always_comb begin
      data = regs_q[rs_addr[i]];
      if (rs_addr[i] == '0) begin
        data = '0;
      end else if (hit_lo) begin
        data = wb_data;
      end else if (hit_hi) begin
        data = wb_data2;
      end
    end
    // The final pending write arriving now is forwarded, so no stall is needed.
    assign raw[i] = pending & ~((cnt[rs_addr[i]] == CNT_W'(1)) & (hit_lo | hit_hi));
`else
    // Plain read mux; a write-back becomes visible on the following cycle.
    always_comb begin
      data = regs_q[rs_addr[i]];
      if (rs_addr[i] == '0) begin
        data = '0;
      end
    end
    assign raw[i] = pending;
`endif
    assign rd_data[i*DATA_W +: DATA_W] = data;
  end

  assign sat = (dec_rd_we & (cnt[dec_rd] == CntMax)) | (dec_pair & (cnt[rd_partner] == CntMax));

  assign hazard = dec_valid & ((|raw) | sat);

  // Scoreboard activity summary.
  always_comb begin
    sb_busy = 1'b0;
    for (int r = 1; r < NumRegs; r++) begin
      sb_busy = sb_busy | (cnt[r] != '0);
    end
  end

endmodule

// File: doc/id_regfile_sb.md
# id_regfile_sb

Parametrised decode-stage register file with an integrated per-register scoreboard, replacing the fixed two-read / 64-entry register file and the external stall logic of the ID stage. It provides NUM_RD combinational read ports and one write-back port with optional paired write (second data word to the partner register). It counts in-flight writes per destination register and raises `hazard` when a decoded source or destination cannot proceed. It sits between the IF/ID register and the ID/EX register, fed from WB.

## Interface
- `DATA_W`, 32: register width in bits
- `ADDR_W`, 6: register address width; 2^ADDR_W registers, register 0 hard-wired to zero
- `NUM_RD`, 2: number of read ports
- `CNT_W`, 2: scoreboard counter width; max in-flight writes per register = 2^CNT_W-1
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `dec_valid`  in  1  a decoded instruction is presented this cycle
- `dec_rs`  in  NUM_RD*ADDR_W  source addresses, port i at bits [i*ADDR_W +: ADDR_W]
- `dec_rs_used`  in  NUM_RD  source i is actually read by the instruction
- `dec_rd`  in  ADDR_W  destination address
- `dec_rd_we`  in  1  instruction writes `dec_rd`
- `dec_pair`  in  1  instruction also writes partner register `dec_rd ^ 1`
- `iss`  in  1  instruction leaves ID this cycle (must equal `dec_valid & ~hazard & ~ctrl_stall`)
- `rd_data`  out  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- `wb_en`  in  1  write-back valid
- `wb_addr`  in  ADDR_W  write-back address
- `wb_data`  in  DATA_W  data for `wb_addr`
- `wb_pair`  in  1  paired write-back
- `wb_data2`  in  DATA_W  data for `wb_addr ^ 1` when `wb_pair`
- `hazard`  out  1  decoded instruction must stall
- `sb_busy`  out  1  any scoreboard counter nonzero

## Operation
- Write: on `wb_en`, reg[wb_addr] <= wb_data. If `wb_pair`, reg[wb_addr^1] <= wb_data2. Writes targeting register 0 are dropped; the partner write is still performed.
- Read: `rd_data[i]` = reg[dec_rs[i]], or 0 if the address is 0.
- Scoreboard: each register r≠0 has a CNT_W-bit counter cnt[r].
  - inc[r] = `iss & dec_rd_we & (dec_rd==r | dec_pair & (dec_rd^1)==r)`
  - dec[r] = `wb_en & (wb_addr==r | wb_pair & (wb_addr^1)==r)`
  - Next value: inc&~dec → +1; dec&~inc → -1; both → unchanged.
  - dec with cnt=0 is a protocol error: the counter holds at 0 and does not wrap.
  - cnt[0] is constant 0.
- Hazard is combinational and is the OR of:
  - RAW: for any i with `dec_rs_used[i]` and dec_rs[i]≠0 and cnt≠0, except the case cnt==1 with a coincident write-back to that address, which is bypassed (see Configuration).
  - Saturation: `dec_rd_we` and cnt[dec_rd]==max, or `dec_pair` and cnt[dec_rd^1]==max.
  - `hazard` is forced to 0 when `dec_valid`=0.
- `sb_busy` = OR of all counters nonzero.

## Timing
- Reads and `hazard` are combinational from the current-cycle inputs and register/counter state; no read latency.
- Register and counter updates take effect at the next rising edge.
- A write-back in cycle N is visible on the plain read path in cycle N+1, or in cycle N when the bypass is enabled.
- Reset (asynchronous, any time, including mid-stream): all registers and counters go to 0 immediately. Resulting values: `rd_data`=0, `sb_busy`=0, `hazard`=0 until a saturated condition recurs.
- Issue and write-back to the same register in the same cycle leave cnt unchanged.

## Configuration
- `ID_RF_BYPASS_EN` defined: write-to-read bypass is compiled in.
  - If `wb_en` and read address == wb_addr (or wb_addr^1 with `wb_pair`), and the address ≠0, `rd_data` returns the incoming data.
  - The RAW exception for cnt==1 with a coincident write-back applies.
- Not defined: no bypass; the RAW hazard holds for any cnt≠0, costing one extra stall cycle after the producing write-back.

## Structure
- Shared package `id_rf_pkg`: default DATA_W/ADDR_W/CNT_W constants and a `partner(addr)` function (addr ^ 1).
- Sub-module `id_sb_cnt`: one saturating up/down counter with inc/dec/async clear, instantiated 2^ADDR_W-1 times by generate.
- Register array and read/bypass muxes live in the top module.

## Test plan
- Reset, then read all ports → `rd_data`=0, `sb_busy`=0, `hazard`=0. Assert `rst` mid-burst with cnt[5]=2 → cnt cleared, `sb_busy`=0 in the same cycle.
- Issue rd=5, then decode rs1=5 → `hazard`=1. WB addr 5, data 0xDEADBEEF in the same cycle as a decode reading 5:
  - with bypass → `hazard`=0, `rd_data`=0xDEADBEEF
  - without bypass → `hazard`=1 this cycle, 0 the next cycle with the value read.
- Paired WB addr 8, data 0x11 / data2 0x22 → reg8=0x11, reg9=0x22. Paired issue rd=8 → cnt8=cnt9=1.
- Issue rd=3 three times (CNT_W=2) → 4th decode with rd=3 gives `hazard`=1. One WB to 3 → cnt=2, `hazard` drops.
- Issue rd=7 and WB addr 7 in the same cycle with cnt7=1 → cnt7 stays 1.
- WB addr 0, data 0xFFFF → read of 0 returns 0, `hazard` never set by rs=0. WB addr 0 paired → reg1 gets data2.
